// File: rtl/image_upscaler_if.sv
// Pixel stream bundle for image_upscaler: upstream (sensor) and downstream (sink)
// valid/ready handshakes. The slave modport is the upscaler's view.
interface image_upscaler_if #(
  parameter int pixel_width_p = 16
);
  logic [pixel_width_p-1:0] pixel_i;
  logic                     valid_i;
  logic                     ready_o;
  logic [pixel_width_p-1:0] pixel_o;
  logic                     valid_o;
  logic                     ready_i;

  modport slave (
    input  pixel_i, valid_i, ready_i,
    output ready_o, pixel_o, valid_o
  );

  modport master (
    output pixel_i, valid_i, ready_i,
    input  ready_o, pixel_o, valid_o
  );
endinterface

// File: rtl/image_upscaler.sv
// Frame-buffered nearest-neighbour upscaler: loads one input frame into a RAM,
// then streams the upscaled frame in raster order using replicate counters.
module image_upscaler #(
  parameter int pixel_width_p   = 16,
  parameter int input_width_p   = 80,
  parameter int input_height_p  = 60,
  parameter int output_width_p  = 640,
  parameter int output_height_p = 480
) (
  input  logic              clk_i,
  input  logic              reset_i,
  image_upscaler_if.slave   up_if
);

  localparam int SX    = output_width_p / input_width_p;
  localparam int SY    = output_height_p / input_height_p;
  localparam int DEPTH = input_width_p * input_height_p;
  localparam int XW    = (input_width_p  > 1) ? $clog2(input_width_p)  : 1;
  localparam int YW    = (input_height_p > 1) ? $clog2(input_height_p) : 1;
  localparam int RXW   = (SX > 1) ? $clog2(SX) : 1;
  localparam int RYW   = (SY > 1) ? $clog2(SY) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [XW-1:0]  X_LAST   = XW'(input_width_p - 1);
  localparam logic [YW-1:0]  Y_LAST   = YW'(input_height_p - 1);
  localparam logic [RXW-1:0] RX_LAST  = RXW'(SX - 1);
  localparam logic [RYW-1:0] RY_LAST  = RYW'(SY - 1);
  localparam logic [AW-1:0]  ROW_STEP = AW'(input_width_p);

  typedef enum logic {ST_LOAD, ST_OUTPUT} state_e;

  state_e           state_q, state_d;
  logic [XW-1:0]    in_x_q, in_x_d;
  logic [YW-1:0]    in_y_q, in_y_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [XW-1:0]    src_x_q, src_x_d;
  logic [RXW-1:0]   rep_x_q, rep_x_d;
  logic [YW-1:0]    src_y_q, src_y_d;
  logic [RYW-1:0]   rep_y_q, rep_y_d;
  logic [AW-1:0]    row_base_q, row_base_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             wr_en;
  logic [AW-1:0]    rd_addr;

  logic [pixel_width_p-1:0] mem [DEPTH];
  logic [pixel_width_p-1:0] rd_data_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= ST_LOAD;
      in_x_q     <= '0;
      in_y_q     <= '0;
      wr_addr_q  <= '0;
      src_x_q    <= '0;
      rep_x_q    <= '0;
      src_y_q    <= '0;
      rep_y_q    <= '0;
      row_base_q <= '0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_x_q     <= in_x_d;
      in_y_q     <= in_y_d;
      wr_addr_q  <= wr_addr_d;
      src_x_q    <= src_x_d;
      rep_x_q    <= rep_x_d;
      src_y_q    <= src_y_d;
      rep_y_q    <= rep_y_d;
      row_base_q <= row_base_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    in_x_d     = in_x_q;
    in_y_d     = in_y_q;
    wr_addr_d  = wr_addr_q;
    src_x_d    = src_x_q;
    rep_x_d    = rep_x_q;
    src_y_d    = src_y_q;
    rep_y_d    = rep_y_q;
    row_base_d = row_base_q;
    wr_en      = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (up_if.valid_i && ready_q) begin
          wr_en     = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          if (in_x_q == X_LAST) begin
            in_x_d = '0;
            if (in_y_q == Y_LAST) begin
              in_y_d    = '0;
              wr_addr_d = '0;
              state_d   = ST_OUTPUT;
            end else begin
              in_y_d = in_y_q + 1'b1;
            end
          end else begin
            in_x_d = in_x_q + 1'b1;
          end
        end
      end
      ST_OUTPUT: begin
        // Each source pixel repeats SX times per line and each source line SY times;
        // the counters all wrap to zero together on the final pixel of the frame.
        if (valid_q && up_if.ready_i) begin
          if (rep_x_q == RX_LAST) begin
            rep_x_d = '0;
            if (src_x_q == X_LAST) begin
              src_x_d = '0;
              if (rep_y_q == RY_LAST) begin
                rep_y_d = '0;
                if (src_y_q == Y_LAST) begin
                  src_y_d    = '0;
                  row_base_d = '0;
                  state_d    = ST_LOAD;
                end else begin
                  src_y_d    = src_y_q + 1'b1;
                  row_base_d = row_base_q + ROW_STEP;
                end
              end else begin
                rep_y_d = rep_y_q + 1'b1;
              end
            end else begin
              src_x_d = src_x_q + 1'b1;
            end
          end else begin
            rep_x_d = rep_x_q + 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase

    ready_d = (state_d == ST_LOAD);
    valid_d = (state_d == ST_OUTPUT);
    // Reading at the next position makes rd_data_q always hold the current output pixel.
    rd_addr = row_base_d + AW'(src_x_d);
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_addr_q] <= up_if.pixel_i;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign up_if.ready_o = ready_q;
  assign up_if.valid_o = valid_q;
  assign up_if.pixel_o = valid_q ? rd_data_q : '0;

endmodule

// File: tb/tb_image_upscaler.sv
// Directed bench for image_upscaler on a reduced 16x12 -> 128x48 frame
// (sx=8, sy=4) so that every frame is checked pixel by pixel.
module tb_image_upscaler;
  localparam int IW   = 16;
  localparam int IH   = 12;
  localparam int OW   = 128;
  localparam int OH   = 48;
  localparam int SX   = OW / IW;
  localparam int SY   = OH / IH;
  localparam int NIN  = IW * IH;
  localparam int NOUT = OW * OH;

  logic clk;
  logic reset_i;

  image_upscaler_if #(.pixel_width_p(16)) u_if ();

  image_upscaler #(
    .pixel_width_p  (16),
    .input_width_p  (IW),
    .input_height_p (IH),
    .output_width_p (OW),
    .output_height_p(OH)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .up_if  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  logic [15:0] img [NOUT];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_pix(input logic [15:0] base, input int n);
    int ox;
    int oy;
    ox = n % OW;
    oy = n / OW;
    return base + 16'((oy / SY) * IW + ox / SX);
  endfunction

  task automatic load_frame(input logic [15:0] base, input bit gaps);
    int idx;
    int cyc;
    bit acc;
    idx = 0;
    cyc = 0;
    while (idx < NIN && cyc < NIN * 8) begin
      u_if.valid_i = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      u_if.pixel_i = base + 16'(idx);
      acc = u_if.valid_i && u_if.ready_o;
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
    end
    u_if.valid_i = 1'b0;
    check_val("load_count", idx, NIN);
  endtask

  task automatic collect(input int mode, input bit ign, input int max_n, output int n);
    logic pat [4];
    int cyc;
    int stall_err;
    bit prev_stall;
    logic [15:0] prev_pix;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    n = 0;
    cyc = 0;
    stall_err = 0;
    prev_stall = 1'b0;
    prev_pix = '0;
    while (n < max_n && cyc < max_n * 4 + 100) begin
      u_if.ready_i = (mode == 0) ? 1'b1 : pat[cyc % 4];
      if (ign) begin
        u_if.valid_i = 1'b1;
        u_if.pixel_i = 16'hFFFF;
      end
      if (prev_stall && (u_if.valid_o !== 1'b1 || u_if.pixel_o !== prev_pix)) stall_err++;
      if (u_if.valid_o && u_if.ready_i) begin
        img[n] = u_if.pixel_o;
        n++;
      end
      prev_stall = u_if.valid_o && !u_if.ready_i;
      prev_pix = u_if.pixel_o;
      @(posedge clk); #1;
      cyc++;
    end
    u_if.valid_i = 1'b0;
    if (mode != 0) check_val("bp_stable", stall_err, 0);
  endtask

  task automatic compare_img(input string tag, input logic [15:0] base, input int count);
    int errs;
    errs = 0;
    for (int i = 0; i < count; i++) begin
      if (img[i] !== model_pix(base, i)) errs++;
    end
    check_val(tag, errs, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_i = 1'b0;
    u_if.valid_i = 1'b0;
    u_if.ready_i = 1'b0;
    u_if.pixel_i = '0;

    repeat (10) @(posedge clk);
    #1;
    check_val("rst_valid_o", u_if.valid_o, 0);
    check_val("rst_pixel_o", u_if.pixel_o, 0);
    check_val("rst_ready_o", u_if.ready_o, 0);
    reset_i = 1'b1;
    @(posedge clk); #1;
    check_val("rel_ready_o", u_if.ready_o, 1);
    check_val("rel_valid_o", u_if.valid_o, 0);

    // Frame 1: ramp, no backpressure once collection starts
    load_frame(16'h0000, 1'b0);
    check_val("f1_valid_first", u_if.valid_o, 1);
    check_val("f1_ready_first", u_if.ready_o, 0);
    check_val("f1_pixel_first", u_if.pixel_o, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    check_val("f1_hold_valid", u_if.valid_o, 1);
    check_val("f1_hold_pixel", u_if.pixel_o, 16'h0000);
    collect(0, 1'b0, NOUT, n);
    check_val("f1_count", n, NOUT);
    check_val("f1_valid_end", u_if.valid_o, 0);
    check_val("f1_pixel_end", u_if.pixel_o, 0);
    check_val("f1_ready_end", u_if.ready_o, 1);
    for (int i = 0; i < 8; i++) check_val("f1_row0_rep", img[i], 16'd0);
    check_val("f1_out_0_8",     img[8], 16'd1);
    check_val("f1_out_3_127",   img[3 * OW + 127], 16'd15);
    check_val("f1_out_4_0",     img[4 * OW], 16'd16);
    check_val("f1_out_last",    img[NOUT - 1], 16'd191);
    compare_img("f1_image", 16'h0000, NOUT);

    // Frame 2: backpressure pattern plus ignored input traffic during output
    load_frame(16'h1000, 1'b0);
    collect(1, 1'b1, NOUT, n);
    check_val("f2_count", n, NOUT);
    compare_img("f2_image", 16'h1000, NOUT);

    // Frame 3: ramp again with random input gaps
    load_frame(16'h0000, 1'b1);
    collect(0, 1'b0, NOUT, n);
    check_val("f3_count", n, NOUT);
    compare_img("f3_image", 16'h0000, NOUT);

    // Frame 4: aborted by reset after 1000 transfers
    load_frame(16'h2000, 1'b0);
    collect(0, 1'b0, 1000, n);
    check_val("f4_count", n, 1000);
    compare_img("f4_partial", 16'h2000, 1000);
    check_val("f4_valid_pre", u_if.valid_o, 1);
    #2;
    reset_i = 1'b0;
    #1;
    check_val("f4_rst_valid", u_if.valid_o, 0);
    check_val("f4_rst_pixel", u_if.pixel_o, 0);
    check_val("f4_rst_ready", u_if.ready_o, 0);
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b1;
    @(posedge clk); #1;
    check_val("f4_rel_ready", u_if.ready_o, 1);
    check_val("f4_rel_valid", u_if.valid_o, 0);

    // Frame 5: fresh frame after the abort
    load_frame(16'h3000, 1'b0);
    collect(0, 1'b0, NOUT, n);
    check_val("f5_count", n, NOUT);
    compare_img("f5_image", 16'h3000, NOUT);
    check_val("f5_valid_end", u_if.valid_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/image_upscaler.md
Name: image_upscaler

Overview:
- Frame-buffered nearest-neighbour image upscaler.
- Accepts one full input frame (default 80x60, 16-bit pixels) over a valid/ready stream, then emits the upscaled frame (default 640x480) in raster order over a second valid/ready stream.
- Sits between the thermal sensor pixel stream and the display/pixel sink.
- Processes one frame at a time: load phase, then output phase.

Parameters:
- pixel_width_p, 16: bits per pixel.
- input_width_p, 80: input frame width in pixels.
- input_height_p, 60: input frame height in lines.
- output_width_p, 640: output frame width; must be an integer multiple of input_width_p.
- output_height_p, 480: output frame height; must be an integer multiple of input_height_p.

Ports:
- clk_i  input  1  single clock; all state changes on its rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- pixel_i  input  pixel_width_p  input pixel, raster order (row 0 col 0 first).
- valid_i  input  1  pixel_i valid.
- ready_o  output  1  block can accept an input pixel.
- pixel_o  output  pixel_width_p  output pixel, raster order.
- valid_o  output  1  pixel_o valid.
- ready_i  input  1  downstream accepts pixel_o.

Behaviour:
- Scale factors: sx = output_width_p/input_width_p and sy = output_height_p/input_height_p (defaults 8, 8).
- Output pixel (ox,oy) = input pixel (ox/sx, oy/sy), using floor division.
- Implement the mapping with per-axis replicate counters, not dividers.
- Frame buffer: input_width_p*input_height_p words of pixel_width_p bits. Write address = in_y*input_width_p+in_x.
- States: LOAD and OUTPUT.
- Reset (reset_i low, asynchronous):
  - state=LOAD.
  - All counters 0.
  - valid_o=0, pixel_o=0.
  - ready_o=0 while reset is asserted.
  - Buffer contents are not cleared.
- LOAD:
  - ready_o=1 (from the first edge after reset release), valid_o=0.
  - Each cycle with valid_i&&ready_o writes pixel_i at the current input position and advances in_x, then wraps to in_y.
  - Cycles with valid_i=0 are stalls; no write occurs.
  - On accepting the last pixel (in_x=input_width_p-1, in_y=input_height_p-1), the next state is OUTPUT and the input counters clear.
  - ready_i is ignored in LOAD.
- OUTPUT:
  - ready_o=0 and valid_o=1, both registered, asserted from the first cycle after the last input was accepted.
  - valid_i and pixel_i are ignored.
  - pixel_o must hold the mapped pixel for the current (ox,oy) in any cycle where valid_o=1. With a synchronous-read RAM, prefetch so this holds with zero bubble cycles.
  - Transfer occurs on valid_o&&ready_i. On transfer, advance ox. On ox wrap advance oy. Source read address follows the replicate counters.
  - ready_i=0 stalls: pixel_o and valid_o hold stable.
  - On transfer of pixel (output_width_p-1, output_height_p-1): next state is LOAD, valid_o=0 and ready_o=1 next cycle, output counters clear.
  - Exactly output_width_p*output_height_p transfers per frame (307200 at defaults).
- pixel_o is 0 whenever valid_o=0.
- Reset mid-frame in either state aborts the frame and returns to LOAD at position 0.
- Back-to-back frames are supported: the next frame's LOAD overwrites the buffer.
- Throughput: 1 input pixel/cycle in LOAD; 1 output pixel/cycle in OUTPUT when ready_i=1.

Test Plan:
- Reset release: hold reset_i low 10 cycles, then release -> valid_o=0 and pixel_o=0 during reset; ready_o=1 one edge after release.
- Ramp frame: load 4800 pixels with value=index, ready_i=0 throughout. Then valid_o=1 on the next cycle, with pixel_o=0x0000 and ready_o=0. Then set ready_i=1 and collect 307200 pixels. Required results:
  - out[0][0..7]=0.
  - out[0][8]=1.
  - out[7][639]=79.
  - out[8][0]=80.
  - out[479][639]=4799.
  - valid_o=0 after the final transfer.
- Backpressure: during OUTPUT toggle ready_i 1,0,0,1 -> pixel_o stable while ready_i=0; no pixel is skipped or duplicated in the collected stream.
- Input stalls: in LOAD insert random valid_i=0 gaps -> the output image is identical to the gap-free run.
- Ignored inputs in OUTPUT: drive valid_i=1 with 0xFFFF during OUTPUT -> no buffer change; the output still matches the ramp.
- Mid-frame reset: assert reset_i after 1000 output transfers -> valid_o drops immediately; after release ready_o=1; a full fresh frame then loads and outputs correctly.
